// File: rtl/intc_top.sv
// Wishbone-slave interrupt controller: per-source sync, polarity, edge/level capture,
// pending latch and masking, with a small register file for software servicing.
module intc_top #(
  parameter int unsigned NUM_SRC = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [31:0]        adr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic               irq_any_o
);

  typedef logic [NUM_SRC-1:0] src_t;

  localparam logic [2:0] AdrPend = 3'd0;
  localparam logic [2:0] AdrEn   = 3'd1;
  localparam logic [2:0] AdrMode = 3'd2;
  localparam logic [2:0] AdrPol  = 3'd3;
  localparam logic [2:0] AdrRaw  = 3'd4;
  localparam logic [2:0] AdrId   = 3'd5;
  localparam logic [2:0] AdrSoft = 3'd6;

  src_t        r_en, r_mode, r_pol, r_pend;
  src_t        r_s1, r_s2, r_s3;
  logic        r_ack;
  logic [31:0] r_dat;

  logic        w_req, w_wr;
  logic [2:0]  w_adr;
  logic [31:0] w_bmask;
  src_t        w_en_new, w_mode_new, w_pol_new;
  src_t        w_w1c, w_soft, w_rise, w_act, w_pend_d;
  logic [31:0] w_id, w_rdata;
  logic        w_unused_adr;

  assign w_adr        = adr_i[4:2];
  assign w_unused_adr = ^{adr_i[31:5], adr_i[1:0]};

  // A held strobe is acked every other cycle; the access happens on the acking edge.
  assign w_req = cyc_i & stb_i & ~r_ack;
  assign w_wr  = w_req & we_i;

  assign w_bmask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  assign w_en_new   = src_t'((32'(r_en)   & ~w_bmask) | (dat_i & w_bmask));
  assign w_mode_new = src_t'((32'(r_mode) & ~w_bmask) | (dat_i & w_bmask));
  assign w_pol_new  = src_t'((32'(r_pol)  & ~w_bmask) | (dat_i & w_bmask));

  assign w_w1c  = (w_wr && w_adr == AdrPend) ? src_t'(dat_i & w_bmask) : '0;
  assign w_soft = (w_wr && w_adr == AdrSoft) ? src_t'(dat_i & w_bmask) : '0;

  assign w_rise = r_s2 & ~r_s3;
  assign w_act  = r_pend & r_en;

  // Edge sources: a new set beats a same-cycle W1C. Level sources just track s2.
  assign w_pend_d = (r_mode & (w_rise | w_soft | (r_pend & ~w_w1c))) | (~r_mode & r_s2);

  always_comb begin
    w_id = '1;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (w_act[i]) w_id = 32'(i);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_adr)
      AdrPend: w_rdata = 32'(r_pend);
      AdrEn:   w_rdata = 32'(r_en);
      AdrMode: w_rdata = 32'(r_mode);
      AdrPol:  w_rdata = 32'(r_pol);
      AdrRaw:  w_rdata = 32'(r_s2);
      AdrId:   w_rdata = w_id;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en   <= '0;
      r_mode <= '0;
      r_pol  <= '0;
      r_pend <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_ack  <= 1'b0;
      r_dat  <= '0;
    end else begin
      r_s1   <= irq_i ^ r_pol;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_d;
      r_ack  <= w_req;
      r_dat  <= (w_req && !we_i) ? w_rdata : '0;
      if (w_wr) begin
        case (w_adr)
          AdrEn:   r_en   <= w_en_new;
          AdrMode: r_mode <= w_mode_new;
          AdrPol:  r_pol  <= w_pol_new;
          default: ;
        endcase
      end
    end
  end

  assign ack_o     = r_ack;
  assign dat_o     = r_dat;
  assign irq_o     = w_act;
  assign irq_any_o = |w_act;

endmodule

// File: tb/tb_intc_top.sv
// Directed self-checking bench for intc_top with hand-computed expectations.
module tb_intc_top;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cyc_i, stb_i, we_i;
  logic [31:0] adr_i, dat_i, dat_o;
  logic [3:0]  sel_i;
  logic        ack_o;
  logic [5:0]  irq_i, irq_o;
  logic        irq_any_o;

  int n_total = 0;
  int n_bad   = 0;

  intc_top #(.NUM_SRC(6)) u_dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .adr_i     (adr_i),
    .sel_i     (sel_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .ack_o     (ack_o),
    .irq_i     (irq_i),
    .irq_o     (irq_o),
    .irq_any_o (irq_any_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] off, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = we;
    adr_i = {27'd0, off, 2'b00};
    dat_i = wdat;
    sel_i = sel;
    lat   = 0;
    do begin
      step(1);
      lat++;
    end while (!ack_o && lat < 8);
    rdat  = dat_o;
    if (!ack_o) check("ack_timeout", 32'(ack_o), 32'd1);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] off, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] rd;
    int          lat;
    wb_xfer(1'b1, off, wdat, sel, rd, lat);
  endtask

  task automatic wb_read_chk(input string tag, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    wb_xfer(1'b0, off, 32'd0, 4'hf, rd, lat);
    check(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    rst_i = 1'b1;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    adr_i = '0;
    dat_i = '0;
    sel_i = '0;
    irq_i = '0;
    step(3);
    rst_i = 1'b0;
    step(1);

    // Reset state
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_any", 32'(irq_any_o), 32'd0);
    wb_xfer(1'b0, 3'd0, 32'd0, 4'hf, rd, lat);
    check("rst_pend", rd, 32'd0);
    check("ack_latency", 32'(lat), 32'd1);
    wb_read_chk("rst_en",   3'd1, 32'd0);
    wb_read_chk("rst_mode", 3'd2, 32'd0);
    wb_read_chk("rst_pol",  3'd3, 32'd0);
    wb_read_chk("rst_raw",  3'd4, 32'd0);
    wb_read_chk("rst_id",   3'd5, 32'hffff_ffff);
    wb_read_chk("rst_soft", 3'd6, 32'd0);
    wb_read_chk("rst_rsvd", 3'd7, 32'd0);

    // Edge capture on source 1
    wb_write(3'd2, 32'h02, 4'hf);
    wb_write(3'd1, 32'h02, 4'hf);
    step(2);
    irq_i = 6'h02;
    step(1);
    irq_i = 6'h00;
    step(1);
    check("edge_n2", 32'(irq_o), 32'h00);
    step(1);
    check("edge_n3", 32'(irq_o), 32'h02);
    check("edge_any", 32'(irq_any_o), 32'd1);
    step(3);
    check("edge_hold", 32'(irq_o), 32'h02);
    wb_read_chk("edge_id", 3'd5, 32'd1);
    wb_write(3'd0, 32'h02, 4'hf);
    check("edge_w1c", 32'(irq_o), 32'h00);

    // Level source 0, active-low
    wb_write(3'd2, 32'h00, 4'hf);
    wb_write(3'd1, 32'h01, 4'hf);
    wb_write(3'd3, 32'h01, 4'hf);
    irq_i = 6'h01;
    step(5);
    check("lvl_inactive", 32'(irq_o), 32'h00);
    irq_i = 6'h00;
    step(2);
    check("lvl_n2", 32'(irq_o), 32'h00);
    step(1);
    check("lvl_n3", 32'(irq_o), 32'h01);
    wb_read_chk("lvl_raw", 3'd4, 32'h01);
    wb_write(3'd0, 32'h01, 4'hf);
    check("lvl_w1c_irq", 32'(irq_o), 32'h01);
    wb_read_chk("lvl_w1c_pend", 3'd0, 32'h01);

    // Masking and priority on sources 3 and 5
    wb_write(3'd1, 32'h00, 4'hf);
    wb_write(3'd3, 32'h00, 4'hf);
    step(5);
    wb_write(3'd2, 32'h28, 4'hf);
    irq_i = 6'h28;
    step(1);
    irq_i = 6'h00;
    step(5);
    wb_read_chk("mask_pend", 3'd0, 32'h28);
    check("mask_irq", 32'(irq_o), 32'h00);
    wb_read_chk("mask_id_none", 3'd5, 32'hffff_ffff);
    wb_write(3'd1, 32'h20, 4'hf);
    check("mask_en20", 32'(irq_o), 32'h20);
    wb_read_chk("mask_id5", 3'd5, 32'd5);
    wb_write(3'd1, 32'h28, 4'hf);
    wb_read_chk("mask_id3", 3'd5, 32'd3);

    // W1C colliding with a fresh rise on edge source 2
    wb_write(3'd2, 32'h04, 4'hf);
    wb_write(3'd1, 32'h04, 4'hf);
    irq_i = 6'h04;
    step(1);
    irq_i = 6'h00;
    step(5);
    wb_read_chk("col_pre", 3'd0, 32'h04);
    step(2);
    irq_i = 6'h04;
    step(1);
    irq_i = 6'h00;
    step(1);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    adr_i = 32'h0;
    dat_i = 32'h04;
    sel_i = 4'hf;
    step(1);
    check("col_ack", 32'(ack_o), 32'd1);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    wb_read_chk("col_pend", 3'd0, 32'h04);
    wb_write(3'd0, 32'h04, 4'hf);
    check("col_clear_any", 32'(irq_any_o), 32'd0);
    wb_write(3'd6, 32'h04, 4'hf);
    check("soft_any", 32'(irq_any_o), 32'd1);
    wb_read_chk("soft_rd0", 3'd6, 32'd0);

    // Byte selects, then reset during a strobe
    wb_write(3'd1, 32'h00, 4'hf);
    wb_write(3'd1, 32'hffff_ffff, 4'b0001);
    wb_read_chk("sel_en", 3'd1, 32'h3f);
    wb_write(3'd1, 32'h00, 4'b1110);
    wb_read_chk("sel_keep", 3'd1, 32'h3f);
    step(1);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = 1'b1;
    adr_i = 32'h4;
    dat_i = 32'h15;
    sel_i = 4'hf;
    rst_i = 1'b1;
    step(1);
    check("rstx_ack1", 32'(ack_o), 32'd0);
    step(1);
    check("rstx_ack2", 32'(ack_o), 32'd0);
    rst_i = 1'b0;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    step(1);
    wb_read_chk("rstx_en", 3'd1, 32'd0);
    wb_read_chk("rstx_mode", 3'd2, 32'd0);
    check("rstx_irq", 32'(irq_o), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/intc_top.md
Name: intc_top

Overview:
- Wishbone-slave interrupt controller on the peripheral bus, occupying a new peripheral-switch slave port.
- Collects peripheral interrupt requests (uart int_o, kb int_o, GPIO/RTC/spare) and applies synchronization, polarity, edge/level capture, pending latching and masking.
- Drives the core's hw_interrupt0..5 inputs, which are otherwise tied to 0.
- Software services it through a small register file.

Parameters:
- NUM_SRC, 6, number of interrupt sources and outputs (1..32); bit i of every register maps to source i.

Ports:
- clk_i  in  1  peripheral clock (clk_per domain).
- rst_i  in  1  reset; synchronous, active-high.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  Wishbone write enable.
- adr_i  in  32  byte address; only adr_i[4:2] decoded.
- sel_i  in  4  byte enables for writes.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- ack_o  out  1  Wishbone acknowledge.
- irq_i  in  NUM_SRC  raw interrupt requests.
- irq_o  out  NUM_SRC  per-source request to core, = PEND & EN; irq_o[k] drives hw_interrupt{k}_i.
- irq_any_o  out  1  OR-reduction of irq_o.

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values: EN=0, MODE=0, POL=0, PEND=0, sync/edge flops=0, ack_o=0, dat_o=0, irq_o=0, irq_any_o=0.
- Input path: x = irq_i ^ POL, passed through 2 flops (s1, s2), then 1 history flop s3.
- Edge detect: rise = s2 & ~s3.
- Level source (MODE[i]=0): PEND[i] <= s2[i] every cycle; W1C and SOFT have no effect.
- Edge source (MODE[i]=1): PEND[i] <= rise[i] | soft[i] | (PEND[i] & ~w1c[i]). A set in the same cycle as a W1C of the same bit wins.
- Latency: irq_i change at edge N → PEND at edge N+3 → irq_o/irq_any_o combinational from PEND/EN, visible after N+3.
- Register map (byte offset; adr_i[4:2]):
  - 0x00 PEND: R; W1C (edge sources only).
  - 0x04 EN: RW.
  - 0x08 MODE: RW; 1 = edge.
  - 0x0C POL: RW; 1 = active-low input.
  - 0x10 RAW: R; returns s2.
  - 0x14 ID: R; index of lowest set bit of PEND&EN, 0xFFFFFFFF if none.
  - 0x18 SOFT: W; 1 sets PEND (edge sources only); reads 0.
  - 0x1C: reserved; reads 0, writes ignored.
- Bits at index ≥ NUM_SRC read 0; writes to them are ignored.
- Writes honour sel_i per byte; an unselected byte leaves its register byte unchanged.
- Wishbone handshake:
  - ack_o <= cyc_i & stb_i & ~ack_o, a single-cycle pulse one cycle after the request.
  - A master holding stb gets ack every other cycle.
  - A write commits on the same clock edge that raises ack_o.
  - dat_o is registered alongside ack_o and is 0 whenever ack_o=0.
  - The read value reflects register state before that edge's updates.
  - Every offset is acked, so an unmapped access never hangs.
- POL/MODE change: takes effect through the sync pipeline. Changing POL may create a spurious rise on an edge source; software clears PEND afterwards.
- Reset mid-transaction: ack is suppressed and all state returns to reset values; the master retries.
- EN=0 does not stop PEND latching; enabling a pending bit raises irq_o the next cycle.

Test Plan:
- Reset: after reset, read all offsets → 0, except ID=0xFFFFFFFF. Check irq_o=0 and ack_o arrives exactly 1 cycle after stb.
- Edge capture: MODE=0x02, EN=0x02, pulse irq_i[1] for 1 cycle at edge N → irq_o=0x02 from N+3 and stays after input drops. ID=1. Write PEND=0x02 → irq_o=0 next cycle.
- Level + polarity: MODE=0, POL=0x01, EN=0x01, irq_i[0]=1 → irq_o[0]=0. Drive irq_i[0]=0 → irq_o[0]=1 at +3 cycles. W1C PEND=0x01 → stays 1 while input held low.
- Masking/priority: edge on sources 3 and 5 with EN=0 → PEND=0x28, irq_o=0. Write EN=0x20 → irq_o=0x20, ID=5. Write EN=0x28 → ID=3.
- Collision: W1C PEND[2] on the same edge as a new rise on source 2 (edge mode) → PEND[2]=1. SOFT=0x04 while EN[2]=1 → irq_any_o=1 next cycle.
- Byte select: write EN=0xFFFFFFFF with sel_i=0001 over EN=0 → EN reads 0x0000003F (NUM_SRC=6). Assert rst_i during stb → no ack, EN=0.
